// File: rtl/uart_rx_port_pkg.sv
// Shared types and constants for the memory-mapped UART receive port.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STATE_W   = 3;

    localparam logic [31:0] UART_RX_ADDR = 32'h70;
    localparam logic [31:0] LEDS_ADDR    = 32'h78;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_rx_port_if.sv
// CPU-facing signal bundle of the UART receive port.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_port_if;

    logic        rx;
    logic        uart_read_end;
    logic [31:0] rx_data;
    logic        int_sig;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;

    modport master (
        output rx, uart_read_end,
        input  rx_data, int_sig, rx_valid, overrun, frame_err, parity_err
    );

    modport slave (
        input  rx, uart_read_end,
        output rx_data, int_sig, rx_valid, overrun, frame_err, parity_err
    );
`else
    modport master (
        output rx, uart_read_end,
        input  rx_data, int_sig, rx_valid, overrun, frame_err
    );

    modport slave (
        input  rx, uart_read_end,
        output rx_data, int_sig, rx_valid, overrun, frame_err
    );
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin plus falling-edge detector.
// All flops reset to the idle-high line level so reset never fakes a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
    assign prev_d = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~rx_s_o;

endmodule

// File: rtl/uart_rx_port.sv
// UART receiver with a one-byte holding register read by the CPU at UART_RX_ADDR.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN selects 8E1 and adds parity_err.
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_port_if.slave  bus
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge (or for break to end)
    // START  | half a bit in, confirming the start bit
    // DATA   | sampling 8 data bits LSB first at bit centres
    // PARITY | sampling the even-parity bit (parity build only)
    // STOP   | sampling the stop bit, commit or flag frame error

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (bus.rx),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;
    logic                 int_q, int_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 commit;
`ifdef UART_RX_PARITY_EN
    logic                 pbad_q, pbad_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        int_d   = 1'b0;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = perr_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (brk_q) begin
                    if (rx_s) brk_d = 1'b0;
                end else if (rx_fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    pbad_d  = (^shift_q) ^ rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    if (pbad_q) perr_d = 1'b1;
                    commit = rx_s & ~pbad_q;
`else
                    commit = rx_s;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.uart_read_end && valid_q) valid_d = 1'b0;

        // A commit in the same cycle as a read overrides the read.
        if (commit) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
            int_d   = 1'b1;
            if (valid_q && !bus.uart_read_end) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            int_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            int_q   <= int_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.rx_data   = {{(32-DATA_BITS){1'b0}}, hold_q};
    assign bus.int_sig   = int_q;
    assign bus.rx_valid  = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 16 clocks per bit; exercises the parity
// build as well when UART_RX_PARITY_EN is defined.
module tb_uart_rx_port;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edge (counted from the edge before the start bit is driven) at which the
    // stop bit centre is taken: 2 sync flops + edge register, half bit, then full bits.
    localparam int COMMIT_CYC = CPB / 2 + 3 + CPB * (NBITS - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_port_if bus ();

    uart_rx_port #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests   = 0;
    int fails   = 0;
    int int_cnt = 0;
    int run     = 0;
    int max_run = 0;
    int base    = 0;

    always @(negedge clk) begin
        if (bus.int_sig === 1'b1) begin
            int_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int rd_cyc,
                        input logic par_flip = 1'b0);
        logic [NBITS-1:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^b) ^ par_flip;
`else
        bits[0]   = par_flip & 1'b0;
`endif
        bits[NBITS-1] = stop;
        @(posedge clk); #1;
        for (int c = 0; c < NBITS * CPB; c++) begin
            bus.rx            = bits[c / CPB];
            bus.uart_read_end = (c == rd_cyc);
            @(posedge clk); #1;
        end
        bus.uart_read_end = 1'b0;
    endtask

    task automatic read_pulse();
        @(posedge clk); #1;
        bus.uart_read_end = 1'b1;
        @(posedge clk); #1;
        bus.uart_read_end = 1'b0;
    endtask

    initial begin
        bus.rx            = 1'b1;
        bus.uart_read_end = 1'b0;
        rst               = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data",   bus.rx_data,          32'h0);
        check("rst_int_sig",   32'(bus.int_sig),     32'd0);
        check("rst_rx_valid",  32'(bus.rx_valid),    32'd0);
        check("rst_overrun",   32'(bus.overrun),     32'd0);
        check("rst_frame_err", 32'(bus.frame_err),   32'd0);
`ifdef UART_RX_PARITY_EN
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Basic 0xA5 frame and CPU read
        base = int_cnt;
        send(8'hA5, 1'b1, -1);
        @(negedge clk);
        check("a5_data",  bus.rx_data,            32'h0000_00A5);
        check("a5_valid", 32'(bus.rx_valid),      32'd1);
        check("a5_int",   32'(int_cnt - base),    32'd1);
        read_pulse();
        @(negedge clk);
        check("a5_read_valid", 32'(bus.rx_valid), 32'd0);
        check("a5_read_data",  bus.rx_data,       32'h0000_00A5);

        // Short glitch must be rejected as a false start
        base = int_cnt;
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_int",   32'(int_cnt - base), 32'd0);
        check("glitch_valid", 32'(bus.rx_valid),   32'd0);
        base = int_cnt;
        send(8'h3C, 1'b1, -1);
        @(negedge clk);
        check("3c_data", bus.rx_data,         32'h0000_003C);
        check("3c_int",  32'(int_cnt - base), 32'd1);
        read_pulse();

        // Overrun, then read coinciding with a commit
        @(negedge clk);
        check("pre_overrun", 32'(bus.overrun), 32'd0);
        base = int_cnt;
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        @(negedge clk);
        check("ovr_data", bus.rx_data,         32'h0000_0022);
        check("ovr_flag", 32'(bus.overrun),    32'd1);
        check("ovr_int",  32'(int_cnt - base), 32'd2);
        base = int_cnt;
        send(8'h33, 1'b1, COMMIT_CYC - 1);
        @(negedge clk);
        check("race_valid", 32'(bus.rx_valid),   32'd1);
        check("race_data",  bus.rx_data,         32'h0000_0033);
        check("race_ovr",   32'(bus.overrun),    32'd1);
        check("race_int",   32'(int_cnt - base), 32'd1);
        read_pulse();
        @(negedge clk);
        check("race_read_valid", 32'(bus.rx_valid), 32'd0);

        // Framing error followed by a long break
        base = int_cnt;
        send(8'h5A, 1'b0, -1);
        repeat (40 * CPB) @(posedge clk);
        @(negedge clk);
        check("ferr_flag",  32'(bus.frame_err),  32'd1);
        check("ferr_valid", 32'(bus.rx_valid),   32'd0);
        check("ferr_int",   32'(int_cnt - base), 32'd0);
        check("ferr_data",  bus.rx_data,         32'h0000_0033);
        @(posedge clk); #1;
        bus.rx = 1'b1;
        repeat (20) @(posedge clk);
        base = int_cnt;
        send(8'h01, 1'b1, -1);
        @(negedge clk);
        check("01_data",  bus.rx_data,         32'h0000_0001);
        check("01_valid", 32'(bus.rx_valid),   32'd1);
        check("01_int",   32'(int_cnt - base), 32'd1);

        // Reset in the middle of data bit 4 of a 0xFF frame
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_data",  bus.rx_data,        32'h0);
        check("abort_valid", 32'(bus.rx_valid),  32'd0);
        check("abort_int",   32'(bus.int_sig),   32'd0);
        check("abort_ovr",   32'(bus.overrun),   32'd0);
        check("abort_ferr",  32'(bus.frame_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6 * CPB) @(posedge clk);
        base = int_cnt;
        send(8'h81, 1'b1, -1);
        @(negedge clk);
        check("81_data",  bus.rx_data,         32'h0000_0081);
        check("81_valid", 32'(bus.rx_valid),   32'd1);
        check("81_int",   32'(int_cnt - base), 32'd1);
        check("81_ovr",   32'(bus.overrun),    32'd0);

`ifdef UART_RX_PARITY_EN
        read_pulse();
        base = int_cnt;
        send(8'h07, 1'b1, -1, 1'b1);
        @(negedge clk);
        check("par_bad_flag",  32'(bus.parity_err), 32'd1);
        check("par_bad_valid", 32'(bus.rx_valid),   32'd0);
        check("par_bad_int",   32'(int_cnt - base), 32'd0);
        base = int_cnt;
        send(8'h07, 1'b1, -1);
        @(negedge clk);
        check("par_ok_data",  bus.rx_data,         32'h0000_0007);
        check("par_ok_valid", 32'(bus.rx_valid),   32'd1);
        check("par_ok_int",   32'(int_cnt - base), 32'd1);
`endif

        check("int_width", 32'(max_run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
